// File: rtl/ram_pkg.sv
// Shared sizing and types for the 16x8 scratch register-file RAM.
// Imported by the RAM and by anything that drives its address/data buses.
package ram_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/ram_16x8.sv
// 16-entry x 8-bit single-port register-file RAM: synchronous write,
// combinational read, synchronous active-high reset clearing every word.
module ram_16x8
    import ram_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  writeE,
    input  addr_t adr,
    input  data_t din,
    output data_t dout
);

    data_t r_mem [DEPTH];

    // Storage update: reset clears all words and wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
        end else if (writeE) begin
            r_mem[adr] <= din;
        end
    end

    // No write bypass: a word written this edge becomes visible only after it.
    assign dout = r_mem[adr];

endmodule

// File: tb/tb_ram_16x8.sv
// Scoreboard bench for ram_16x8: a reference memory model produces expected
// read data, which is queued at stimulus time and popped when dout is sampled.
module tb_ram_16x8;
    import ram_pkg::*;

    logic  clk;
    logic  reset;
    logic  writeE;
    addr_t adr;
    data_t din;
    data_t dout;

    data_t model [DEPTH];
    data_t exp_q [$];
    int    n_checks;
    int    n_fail;

    ram_16x8 dut (
        .clk    (clk),
        .reset  (reset),
        .writeE (writeE),
        .adr    (adr),
        .din    (din),
        .dout   (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply one clock edge with the given controls and mirror it in the model.
    task automatic do_edge(input logic rst, input logic we, input addr_t a, input data_t d);
        @(negedge clk);
        reset  = rst;
        writeE = we;
        adr    = a;
        din    = d;
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = 8'h00;
        end else if (we) begin
            model[a] = d;
        end
        #1;
        reset  = 1'b0;
        writeE = 1'b0;
    endtask

    task automatic check_read(input string tag, input addr_t a);
        data_t e;
        @(negedge clk);
        writeE = 1'b0;
        adr    = a;
        exp_q.push_back(model[a]);
        #1;
        e = exp_q.pop_front();
        check_eq($sformatf("%s[%0d]", tag, a), 32'(dout), 32'(e));
    endtask

    initial begin
        addr_t a;
        data_t e;
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b0;
        writeE   = 1'b0;
        adr      = 4'h0;
        din      = 8'h00;

        // Reset, then sweep every address expecting zero.
        do_edge(1'b1, 1'b0, 4'h0, 8'h00);
        for (int i = 0; i < DEPTH; i++) check_read("reset_sweep", addr_t'(i));

        // Write 0x80 to address 0 twice, then read back.
        do_edge(1'b0, 1'b1, 4'h0, 8'h80);
        do_edge(1'b0, 1'b1, 4'h0, 8'h80);
        check_read("wr_rd", 4'h0);
        check_read("wr_rd", 4'h1);
        check_eq("model_w0", 32'(model[0]), 32'h80);

        // Downward wrap 1,0,15,14 then upward through the wrap again.
        a = 4'h1;
        for (int i = 0; i < 4; i++) begin
            check_read("wrap_dn", a);
            a = a - 4'h1;
        end
        a = 4'hE;
        for (int i = 0; i < 6; i++) begin
            check_read("wrap_up", a);
            a = a + 4'h1;
        end

        // Fill every word with {A, adr}, then read all back.
        for (int i = 0; i < DEPTH; i++) do_edge(1'b0, 1'b1, addr_t'(i), {4'hA, 4'(i)});
        for (int i = 0; i < DEPTH; i++) check_read("fill", addr_t'(i));
        check_eq("fill_last", 32'(model[15]), 32'hAF);

        // Reset and write on the same edge: reset wins everywhere.
        do_edge(1'b1, 1'b1, 4'h3, 8'h5A);
        for (int i = 0; i < DEPTH; i++) check_read("rst_prio", addr_t'(i));

        // Read-during-write timing at address 7.
        @(negedge clk);
        writeE = 1'b1;
        adr    = 4'h7;
        din    = 8'h3C;
        exp_q.push_back(model[7]);
        #1;
        e = exp_q.pop_front();
        check_eq("rdw_before", 32'(dout), 32'(e));
        @(posedge clk);
        model[7] = 8'h3C;
        #1;
        writeE = 1'b0;
        exp_q.push_back(model[7]);
        #1;
        e = exp_q.pop_front();
        check_eq("rdw_after", 32'(dout), 32'(e));
        din = 8'hFF;
        @(posedge clk);
        @(posedge clk);
        #1;
        exp_q.push_back(model[7]);
        e = exp_q.pop_front();
        check_eq("hold_din_ff", 32'(dout), 32'(e));
        check_read("hold_nb", 4'h6);
        check_read("hold_nb", 4'h8);

        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
